// File: rtl/risky_fetch.sv
// risky_fetch: instruction fetch front end.
// Sequential PC generation, single-cycle-latency imem interface, small
// in-order instruction queue and a valid/ready port towards decode.
// Redirects from execute flush the queue and drop the in-flight response.
// Optional performance counters are enabled with `define RISKY_FETCH_PERF_EN.
module risky_fetch #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              QUEUE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
`ifdef RISKY_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_bubbles,
  output logic [31:0]     perf_flushed
`endif
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  // one spare bit so count + inflight can never alias in the compare
  localparam int CW = AW + 2;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;     // PC of the request whose response is due next cycle
  logic            inflight;

  logic [XLEN-1:0] q_inst [QUEUE_DEPTH];
  logic [XLEN-1:0] q_pc   [QUEUE_DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     count;

  logic [CW-1:0]   credit_used;
  logic            grant;
  logic            push;
  logic            pop;

  // A request is only issued when a queue slot is guaranteed for its response,
  // so the queue can never overflow even with decode stalled.
  assign credit_used = CW'(count) + CW'(inflight);
  assign imem_req    = !rst && !redirect_valid && (credit_used < CW'(QUEUE_DEPTH));
  assign imem_addr   = fetch_pc;
  assign grant       = imem_req && imem_gnt;

  // Responses without a matching request, or arriving during a redirect, are dropped.
  assign push = !rst && !redirect_valid && imem_rvalid && inflight;

  assign inst_valid = !rst && !redirect_valid && (count != '0);
  assign inst       = q_inst[rptr];
  assign inst_pc    = q_pc[rptr];
  assign pop        = inst_valid && inst_ready;

  // Fetch PC, in-flight tracking and queue pointers; redirect flushes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      inflight <= grant;
      if (grant) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        req_pc   <= fetch_pc;
      end
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Queue storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wptr] <= imem_rdata;
      q_pc[wptr]   <= req_pc;
    end
  end

`ifdef RISKY_FETCH_PERF_EN
  logic [31:0] drop_cnt;
  logic [32:0] flush_sum;

  assign drop_cnt  = 32'(count) + 32'(imem_rvalid && inflight);
  assign flush_sum = {1'b0, perf_flushed} + {1'b0, drop_cnt};

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop && perf_fetched != '1)                       perf_fetched <= perf_fetched + 32'd1;
      if (inst_ready && !inst_valid && perf_bubbles != '1) perf_bubbles <= perf_bubbles + 32'd1;
      if (redirect_valid) perf_flushed <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end
`endif

endmodule
